// File: rtl/net_tx_pkg.sv
// Shared types and constants for the Hack network serial transmitter.
// The baud tick is kept generic so that the receive side can reuse it.
package net_tx_pkg;

  localparam int unsigned DATA_BITS  = 16;
  localparam int unsigned FRAME_BITS = 18;
  localparam int unsigned IDX_W      = 4;

  typedef logic [DATA_BITS-1:0] word_t;

  localparam word_t STATUS_FULL = 16'h0001;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_e;

  // CPU-visible status word derived from the holding-register flag
  function automatic word_t status_word(input logic full);
    return full ? STATUS_FULL : word_t'(0);
  endfunction

endpackage

// File: rtl/net_tx_if.sv
// CPU-side bus of the network transmitter: write data, load strobe,
// status readback and the serial line.
interface net_tx_if;
  import net_tx_pkg::*;

  word_t in;
  logic  load;
  word_t out;
  logic  tx;

  modport master (output in, output load, input out, input tx);
  modport slave  (input in, input load, output out, output tx);

endinterface

// File: rtl/net_baud_tick.sv
// Bit-period timer: emits a one-cycle tick every CLKS_PER_BIT cycles and
// restarts from zero while clear is held.
module net_baud_tick #(
  parameter int unsigned CLKS_PER_BIT = 289
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic tick_c
);

  localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    if (clear || (cnt_q == LAST)) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick_c = (cnt_q == LAST) && !clear;

endmodule

// File: rtl/net_tx.sv
// Hack network transmitter: one-word holding register feeding a shifter that
// sends start bit, 16 data bits LSB first and stop bit on a single line.
module net_tx
  import net_tx_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 289
) (
  input  logic     clk,
  input  logic     reset,
  net_tx_if.slave  bus
);

  tx_state_e          state_q;
  tx_state_e          state_d;
  word_t              hold_q;
  word_t              hold_d;
  logic               hold_full_q;
  logic               hold_full_d;
  word_t              shift_q;
  word_t              shift_d;
  logic [IDX_W-1:0]   bit_idx_q;
  logic [IDX_W-1:0]   bit_idx_d;
  logic               tx_q;
  logic               tx_d;
  word_t              out_q;
  word_t              out_d;

  logic               baud_clr_c;
  logic               baud_tick_c;
  logic               drain_c;

  // Counter is held at zero in IDLE so the start bit gets a full period
  net_baud_tick #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_baud (
    .clk    (clk),
    .reset  (reset),
    .clear  (baud_clr_c),
    .tick_c (baud_tick_c)
  );

  always_comb begin
    state_d     = state_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    shift_d     = shift_q;
    bit_idx_d   = bit_idx_q;
    tx_d        = tx_q;
    out_d       = out_q;
    baud_clr_c  = 1'b0;
    drain_c     = 1'b0;

    case (state_q)
      IDLE: begin
        baud_clr_c = 1'b1;
        tx_d       = 1'b1;
        if (hold_full_q) begin
          drain_c = 1'b1;
          state_d = START;
          tx_d    = 1'b0;
        end
      end
      START: begin
        if (baud_tick_c) begin
          state_d   = DATA;
          tx_d      = shift_q[0];
          bit_idx_d = '0;
        end
      end
      DATA: begin
        if (baud_tick_c) begin
          shift_d   = {1'b0, shift_q[DATA_BITS-1:1]};
          bit_idx_d = bit_idx_q + IDX_W'(1);
          if (bit_idx_q == IDX_W'(DATA_BITS - 1)) begin
            state_d = STOP;
            tx_d    = 1'b1;
          end else begin
            tx_d    = shift_q[1];
          end
        end
      end
      STOP: begin
        if (baud_tick_c) begin
          if (hold_full_q) begin
            drain_c = 1'b1;
            state_d = START;
            tx_d    = 1'b0;
          end else begin
            state_d = IDLE;
            tx_d    = 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
      end
    endcase

    if (drain_c) begin
      shift_d = hold_q;
    end

    // A write lands if the register is empty or is being emptied this cycle
    if (drain_c) begin
      hold_full_d = bus.load;
    end else if (bus.load && !hold_full_q) begin
      hold_full_d = 1'b1;
    end
    if (bus.load && (drain_c || !hold_full_q)) begin
      hold_d = bus.in;
    end

    out_d = status_word(hold_full_d);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      shift_q     <= '0;
      bit_idx_q   <= '0;
      tx_q        <= 1'b1;
      out_q       <= '0;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      shift_q     <= shift_d;
      bit_idx_q   <= bit_idx_d;
      tx_q        <= tx_d;
      out_q       <= out_d;
    end
  end

  assign bus.tx  = tx_q;
  assign bus.out = out_q;

endmodule

// File: tb/tb_net_tx.sv
// Scoreboard bench for net_tx: words are queued as they are loaded and a
// line monitor checks every cycle of each frame against the queued word.
module tb_net_tx;
  import net_tx_pkg::*;

  localparam int unsigned CPB       = 4;
  localparam int unsigned FRAME_CYC = FRAME_BITS * CPB;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  net_tx_if bus();

  net_tx #(.CLKS_PER_BIT(CPB)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vec_cnt = 0;
  int err_cnt = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h want %0h at cycle %0d", tag, obs, exp, cyc);
    end
  endtask

  word_t       exp_q[$];
  int unsigned frames_done = 0;
  int unsigned cur_start   = 0;
  int unsigned prev_start  = 0;
  bit          in_frame    = 1'b0;

  // Line monitor: sampled just after the falling edge, away from updates
  initial begin : mon
    word_t                 w;
    logic [FRAME_BITS-1:0] fr;
    bit                    abort;
    forever begin
      @(negedge clk); #1;
      if (!reset && bus.tx === 1'b0) begin
        if (exp_q.size() == 0) begin
          check_val("unexpected_frame", 32'(bus.tx), 32'd1);
          repeat (FRAME_CYC) @(negedge clk);
        end else begin
          w          = exp_q.pop_front();
          fr         = {1'b1, w, 1'b0};
          prev_start = cur_start;
          cur_start  = cyc;
          in_frame   = 1'b1;
          abort      = 1'b0;
          for (int b = 0; b < int'(FRAME_BITS) && !abort; b++) begin
            for (int c = 0; c < int'(CPB) && !abort; c++) begin
              if (b != 0 || c != 0) begin
                @(negedge clk); #1;
              end
              if (reset) abort = 1'b1;
              else check_val($sformatf("tx_bit%0d_w%04h", b, w), 32'(bus.tx), 32'(fr[b]));
            end
          end
          in_frame = 1'b0;
          if (!abort) frames_done++;
        end
      end
    end
  end

  task automatic load_word(input word_t w, output int unsigned edge_n);
    @(negedge clk);
    bus.in   = w;
    bus.load = 1'b1;
    edge_n   = cyc + 1;
    @(negedge clk);
    bus.load = 1'b0;
  endtask

  task automatic wait_frames(input int n);
    int unsigned tgt;
    int          budget;
    tgt    = frames_done + n;
    budget = n * FRAME_CYC + 40;
    while (frames_done < tgt && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    check_val("frames_done", frames_done, tgt);
  endtask

  initial begin : stim
    int unsigned n;
    int unsigned m;
    int          budget;
    word_t       w;

    bus.in   = '0;
    bus.load = 1'b0;
    reset    = 1'b1;
    repeat (3) @(negedge clk);
    check_val("rst_tx", 32'(bus.tx), 32'd1);
    check_val("rst_out", 32'(bus.out), 32'h0);
    reset = 1'b0;

    // Idle after reset
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check_val("idle_tx", 32'(bus.tx), 32'd1);
      check_val("idle_out", 32'(bus.out), 32'h0);
    end

    // Single word and load-to-line latency
    exp_q.push_back(16'hA5C3);
    load_word(16'hA5C3, n);
    check_val("single_out_full", 32'(bus.out), 32'h1);
    check_val("single_tx_idle", 32'(bus.tx), 32'd1);
    @(negedge clk);
    check_val("single_out_empty", 32'(bus.out), 32'h0);
    check_val("single_tx_start", 32'(bus.tx), 32'd0);
    wait_frames(1);
    check_val("single_start_cyc", cur_start, n + 1);

    // Back-to-back frames
    exp_q.push_back(16'h0001);
    load_word(16'h0001, n);
    @(negedge clk);
    exp_q.push_back(16'hFFFF);
    load_word(16'hFFFF, m);
    check_val("b2b_out_full", 32'(bus.out), 32'h1);
    wait_frames(2);
    check_val("b2b_first_start", prev_start, n + 1);
    check_val("b2b_gap", cur_start - prev_start, FRAME_CYC);

    // Overflow: third write while full is dropped
    exp_q.push_back(16'h1111);
    load_word(16'h1111, n);
    repeat (3) @(negedge clk);
    exp_q.push_back(16'h2222);
    load_word(16'h2222, m);
    check_val("ovf_out_full", 32'(bus.out), 32'h1);
    load_word(16'h3333, m);
    check_val("ovf_out_still_full", 32'(bus.out), 32'h1);
    wait_frames(2);
    m = frames_done;
    repeat (2 * FRAME_CYC) @(negedge clk);
    check_val("ovf_no_extra_frame", frames_done, m);
    check_val("ovf_queue_empty", 32'(exp_q.size()), 32'd0);

    // Load on the exact edge the holding word drains
    exp_q.push_back(16'h0F0F);
    exp_q.push_back(16'h5555);
    @(negedge clk);
    bus.in   = 16'h0F0F;
    bus.load = 1'b1;
    n        = cyc + 1;
    @(negedge clk);
    bus.in   = 16'h5555;
    check_val("sim_out_first", 32'(bus.out), 32'h1);
    @(negedge clk);
    bus.load = 1'b0;
    check_val("sim_out_kept", 32'(bus.out), 32'h1);
    check_val("sim_tx_start", 32'(bus.tx), 32'd0);
    wait_frames(2);
    check_val("sim_first_start", prev_start, n + 1);
    check_val("sim_gap", cur_start - prev_start, FRAME_CYC);

    // Reset during data bit 7 with a second word buffered
    w = 16'h1234;
    exp_q.push_back(w);
    load_word(w, n);
    load_word(16'hBEEF, m);
    budget = 20;
    while (!in_frame && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    check_val("rst_frame_seen", 32'(in_frame), 32'd1);
    budget = 100;
    while (cyc != cur_start + 33 && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    check_val("rst_reach_bit7", cyc, cur_start + 33);
    check_val("rst_pre_tx", 32'(bus.tx), 32'(w[7]));
    check_val("rst_pre_out", 32'(bus.out), 32'h1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_val("rst_mid_tx", 32'(bus.tx), 32'd1);
    check_val("rst_mid_out", 32'(bus.out), 32'h0);
    check_val("rst_queue_drained", 32'(exp_q.size()), 32'd0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check_val("rst_idle_tx", 32'(bus.tx), 32'd1);
    end
    exp_q.push_back(16'h00FF);
    load_word(16'h00FF, n);
    wait_frames(1);
    check_val("rst_clean_start", cur_start, n + 1);

    // Nothing left to send, and the discarded word never appears
    m = frames_done;
    repeat (2 * FRAME_CYC) @(negedge clk);
    check_val("final_no_frame", frames_done, m);
    check_val("final_queue_empty", 32'(exp_q.size()), 32'd0);
    check_val("final_tx", 32'(bus.tx), 32'd1);
    check_val("final_out", 32'(bus.out), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
